// File: rtl/apb_pkg.sv
// Shared APB3 master definitions: FSM state encodings and response codes.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   typedef enum logic [1:0] {
      RSP_OK      = 2'd0,
      RSP_SLVERR  = 2'd1,
      RSP_TIMEOUT = 2'd2
   } apb_rsp_e;

   typedef struct packed {
      logic err;
      logic timeout;
   } rsp_flags_t;

   // Map a response code onto the rsp_err / rsp_timeout pair.
   function automatic rsp_flags_t rsp_flags(input apb_rsp_e code);
      rsp_flags_t f;
      f.err     = (code != RSP_OK);
      f.timeout = (code == RSP_TIMEOUT);
      return f;
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating PREADY-low counter. expired_o is registered and rises once TIMEOUT_CYC-1
// waits are counted, so the next counted wait cycle is the one that expires.
module apb_wait_timer #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CNT_W    = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned LIMIT_M1 = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
   localparam bit          ENABLED  = (TIMEOUT_CYC != 0);
   localparam bit          ARM_NOW  = (TIMEOUT_CYC == 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic             expired_q;

   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign expired_o = expired_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else if (clear_i) begin
         cnt_q     <= '0;
         expired_q <= ARM_NOW;
      end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
         cnt_q     <= cnt_inc;
         expired_q <= ENABLED && (cnt_inc >= CNT_W'(LIMIT_M1));
      end
   end

endmodule

// File: rtl/apb3_fabric_master.sv
// Fabric-side APB3 initiator: valid/ready command stream in, APB3 transfer out,
// valid/ready response stream back with read data, slave error and timeout status.
module apb3_fabric_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              PCLK,
   input  logic              PRESERN,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   apb_state_e        state_q;
   logic              cmd_ready_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              rsp_timeout_q;

   logic       accept;
   logic       timer_enable;
   logic       timer_expired;
   logic       access_done;
   apb_rsp_e   access_code;
   rsp_flags_t access_flags;

   assign accept       = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
   assign timer_enable = (state_q == ST_ACCESS) && !PREADY;

   apb_wait_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wait_timer (
      .clk_i     (PCLK),
      .rst_i     (PRESERN),
      .clear_i   (accept),
      .enable_i  (timer_enable),
      .expired_o (timer_expired)
   );

   // PREADY wins over an expiring count; PSLVERR only matters with PREADY high.
   always_comb begin
      access_code = RSP_OK;
      access_done = 1'b0;
      if (PREADY) begin
         access_code = PSLVERR ? RSP_SLVERR : RSP_OK;
         access_done = 1'b1;
      end else if (timer_expired) begin
         access_code = RSP_TIMEOUT;
         access_done = 1'b1;
      end
      access_flags = rsp_flags(access_code);
   end

   always_ff @(posedge PCLK) begin
      if (PRESERN) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q     <= ST_SETUP;
                  cmd_ready_q <= 1'b0;
                  psel_q      <= 1'b1;
                  pwrite_q    <= cmd_write;
                  paddr_q     <= cmd_addr;
                  pwdata_q    <= cmd_wdata;
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            ST_SETUP: begin
               state_q   <= ST_ACCESS;
               penable_q <= 1'b1;
            end
            ST_ACCESS: begin
               if (access_done) begin
                  state_q       <= ST_RESP;
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= (pwrite_q || access_flags.timeout) ? '0 : PRDATA;
                  rsp_err_q     <= access_flags.err;
                  rsp_timeout_q <= access_flags.timeout;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_fabric_master.sv
// Self-checking bench for apb3_fabric_master with a bench-driven APB slave and a
// transfer-level reference model (timeout 4 cycles).
module tb_apb3_fabric_master;

   localparam int TO = 4;

   logic        PCLK = 1'b0;
   logic        PRESERN;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_addr, last_wdata;

   apb3_fabric_master #(
      .ADDR_W (32), .DATA_W (32), .TIMEOUT_CYC (TO)
   ) dut (
      .PCLK (PCLK), .PRESERN (PRESERN),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
      .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
      .rsp_err (rsp_err), .rsp_timeout (rsp_timeout),
      .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE), .PADDR (PADDR), .PWDATA (PWDATA),
      .PRDATA (PRDATA), .PREADY (PREADY), .PSLVERR (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic garbage_cmd();
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
   endtask

   // One full transfer: the model gives the expected response and ACCESS-cycle count.
   task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int waits, input logic slverr,
                           input int hold, input string tag);
      bit          exp_to;
      logic        exp_err;
      logic [31:0] exp_rd;
      int          n_acc;
      exp_to  = (waits >= TO);
      exp_err = exp_to || slverr;
      exp_rd  = (exp_to || wr) ? 32'h0 : rd;
      n_acc   = exp_to ? TO : waits + 1;

      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s idle_cmd_ready got=%0b exp=1", tag, cmd_ready); end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      @(negedge PCLK);
      garbage_cmd();
      total++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin bad++; $display("FAIL %s setup_ctl got=%0b%0b exp=10", tag, PSEL, PENABLE); end
      total++; if (PADDR !== addr || PWRITE !== wr) begin bad++; $display("FAIL %s setup_addr got=%h/%0b exp=%h/%0b", tag, PADDR, PWRITE, addr, wr); end
      total++; if (PWDATA !== wd) begin bad++; $display("FAIL %s setup_wdata got=%h exp=%h", tag, PWDATA, wd); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL %s setup_cmd_ready got=%0b exp=0", tag, cmd_ready); end

      for (int k = 0; k < n_acc; k++) begin
         @(negedge PCLK);
         total++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin bad++; $display("FAIL %s access%0d_ctl got=%0b%0b exp=11", tag, k, PSEL, PENABLE); end
         total++; if (PADDR !== addr || PWDATA !== wd || PWRITE !== wr) begin bad++; $display("FAIL %s access%0d_stable got=%h/%h exp=%h/%h", tag, k, PADDR, PWDATA, addr, wd); end
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL %s access%0d_early_rsp got=%0b exp=0", tag, k, rsp_valid); end
         if (k == waits) begin
            PREADY = 1'b1; PRDATA = rd; PSLVERR = slverr;
         end else begin
            PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
         end
         garbage_cmd();
      end

      @(negedge PCLK);
      PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      for (int h = 0; h <= hold; h++) begin
         total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL %s resp%0d_valid got=%0b exp=1", tag, h, rsp_valid); end
         total++; if (rsp_rdata !== exp_rd) begin bad++; $display("FAIL %s resp%0d_rdata got=%h exp=%h", tag, h, rsp_rdata, exp_rd); end
         total++; if (rsp_err !== exp_err || rsp_timeout !== exp_to) begin bad++; $display("FAIL %s resp%0d_status got=err%0b/to%0b exp=err%0b/to%0b", tag, h, rsp_err, rsp_timeout, exp_err, exp_to); end
         total++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b0) begin bad++; $display("FAIL %s resp%0d_bus got=%0b%0b%0b exp=000", tag, h, PSEL, PENABLE, cmd_ready); end
         if (h == hold) begin
            rsp_ready = 1'b1; cmd_valid = 1'b0;
         end else begin
            rsp_ready = 1'b0; garbage_cmd();
         end
         @(negedge PCLK);
      end
      rsp_ready = 1'b0;
      total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL %s back_to_idle got=v%0b/r%0b exp=v0/r1", tag, rsp_valid, cmd_ready); end
      total++; if (PSEL !== 1'b0 || PADDR !== addr) begin bad++; $display("FAIL %s idle_hold got=%0b/%h exp=0/%h", tag, PSEL, PADDR, addr); end
      last_addr = addr; last_wdata = wd;
   endtask

   task automatic test_reset();
      PRESERN = 1'b1;
      garbage_cmd();
      repeat (3) @(negedge PCLK);
      total++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_handshake got=%0b%0b exp=00", cmd_ready, rsp_valid); end
      total++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin bad++; $display("FAIL reset_ctl got=%0b%0b%0b exp=000", PSEL, PENABLE, PWRITE); end
      total++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", PADDR, PWDATA, rsp_rdata); end
      total++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin bad++; $display("FAIL reset_status got=%0b%0b exp=00", rsp_err, rsp_timeout); end
      PRESERN = 1'b0; cmd_valid = 1'b0;
      @(negedge PCLK);
      total++; if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin bad++; $display("FAIL reset_release got=%0b/%0b exp=1/0", cmd_ready, PSEL); end
   endtask

   task automatic test_read_basic();
      run_xfer(1'b0, 32'h4005_0004, 32'hDEAD_BEEF, 32'h0000_1234, 0, 1'b0, 0, "read_basic");
   endtask

   task automatic test_write_waits();
      run_xfer(1'b1, 32'h4005_0000, 32'h0000_0001, 32'hFFFF_FFFF, 3, 1'b0, 0, "write_waits");
   endtask

   task automatic test_slverr();
      run_xfer(1'b0, 32'h4005_0008, 32'h0, 32'hA5A5_0001, 2, 1'b1, 0, "read_slverr");
      run_xfer(1'b0, 32'h4005_000C, 32'h0, 32'h5A5A_0002, 3, 1'b0, 0, "read_noise_ok");
      run_xfer(1'b1, 32'h4005_0010, 32'h77, 32'h1111_1111, 1, 1'b1, 0, "write_slverr");
   endtask

   task automatic test_timeout();
      run_xfer(1'b0, 32'h4005_0020, 32'h0, 32'hCAFE_0000, 50, 1'b0, 0, "timeout_abort");
      run_xfer(1'b0, 32'h4005_0024, 32'h0, 32'hCAFE_0004, TO - 1, 1'b0, 0, "timeout_ready_wins");
      run_xfer(1'b1, 32'h4005_0028, 32'h99, 32'h0, TO, 1'b1, 0, "timeout_write");
   endtask

   task automatic test_backpressure();
      run_xfer(1'b0, 32'h4005_0030, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 10, "rsp_hold10");
   endtask

   task automatic test_idle_stable();
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
         @(negedge PCLK);
         total++; if (PSEL !== 1'b0 || PADDR !== last_addr || PWDATA !== last_wdata) begin bad++; $display("FAIL idle_stable%0d got=%0b/%h/%h exp=0/%h/%h", i, PSEL, PADDR, PWDATA, last_addr, last_wdata); end
      end
   endtask

   task automatic test_mid_reset();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4005_0040; cmd_wdata = 32'h0;
      PREADY = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      total++; if (PENABLE !== 1'b1) begin bad++; $display("FAIL midrst_in_access got=%0b exp=1", PENABLE); end
      PRESERN = 1'b1;
      @(negedge PCLK);
      total++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin bad++; $display("FAIL midrst_bus got=%0b%0b exp=00", PSEL, PENABLE); end
      total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin bad++; $display("FAIL midrst_rsp got=%0b/%0b exp=0/0", rsp_valid, cmd_ready); end
      PRESERN = 1'b0;
      @(negedge PCLK);
      total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_release got=%0b/%0b exp=0/1", rsp_valid, cmd_ready); end
      run_xfer(1'b0, 32'h4005_0044, 32'h0, 32'h1357_9BDF, 0, 1'b0, 0, "after_midrst");
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         run_xfer(1'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 6)),
                  1'($urandom), int'($urandom_range(0, 3)), "random");
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         run_xfer(1'(i % 2), 32'h4005_0100 + 32'(i * 4), 32'(i), 32'h1000 + 32'(i), 0, 1'b0, 0, "b2b");
      end
   endtask

   initial begin
      PRESERN = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      last_addr = '0; last_wdata = '0;
      @(negedge PCLK);
      test_reset();
      test_read_basic();
      test_write_waits();
      test_slverr();
      test_timeout();
      test_backpressure();
      test_idle_stable();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
